// File: rtl/reg_file_pkg.sv
// Shared types for the multi-port register file: sweep FSM states and the
// default-width clear pointer type.
package reg_file_pkg;

  typedef enum logic [1:0] {
    RF_INIT,
    RF_READY,
    RF_CLEAR
  } rf_state_e;

  localparam int RF_PTR_W = 5;
  typedef logic [RF_PTR_W-1:0] rf_ptr_t;

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: clear request, ready status, write ports and
// registered read ports. The master side drives requests, the slave side is
// the register file.
interface reg_file_mp_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int SIZE_REGFILE = 5,
  parameter int NUM_RD       = 2,
  parameter int NUM_WR       = 2
);

  logic                                     rg_clr;
  logic                                     rg_ready;
  logic [NUM_WR-1:0]                        rg_wrt_en;
  logic [NUM_WR-1:0][SIZE_REGFILE-1:0]      rg_wrt_dest;
  logic [NUM_WR-1:0][DATA_WIDTH-1:0]        rg_wrt_data;
  logic [NUM_RD-1:0]                        rg_rd_en;
  logic [NUM_RD-1:0][SIZE_REGFILE-1:0]      rg_rd_addr;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0]        rg_rd_data;
  logic [NUM_RD-1:0]                        rg_rd_valid;

  modport master (
    output rg_clr, rg_wrt_en, rg_wrt_dest, rg_wrt_data, rg_rd_en, rg_rd_addr,
    input  rg_ready, rg_rd_data, rg_rd_valid
  );

  modport slave (
    input  rg_clr, rg_wrt_en, rg_wrt_dest, rg_wrt_data, rg_rd_en, rg_rd_addr,
    output rg_ready, rg_rd_data, rg_rd_valid
  );

endinterface

// File: rtl/reg_file_clr_seq.sv
// Clear sweeper: after reset (INIT) or on request (CLEAR) it walks every entry
// once, issuing a zero write per cycle, then returns to READY. ready is
// registered and is high exactly while the FSM sits in READY.
module reg_file_clr_seq
  import reg_file_pkg::*;
#(
  parameter int SIZE_REGFILE = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  output logic                    ready,
  output logic                    sweep_we,
  output logic [SIZE_REGFILE-1:0] sweep_addr
);

  rf_state_e               state, state_nx;
  logic [SIZE_REGFILE-1:0] ptr, ptr_nx;
  logic                    ready_nx;

  // State, pointer and ready flag registers; reset restarts the INIT sweep
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RF_INIT;
      ptr   <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      ready <= ready_nx;
    end
  end

  // Next state and sweep write; the sweep ends when ptr wraps from all-ones
  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    sweep_we   = 1'b0;
    sweep_addr = ptr;
    case (state)
      RF_INIT, RF_CLEAR: begin
        sweep_we = 1'b1;
        ptr_nx   = ptr + 1'b1;
        if (&ptr) state_nx = RF_READY;
      end
      RF_READY: begin
        if (clr) state_nx = RF_CLEAR;
      end
      default: state_nx = RF_INIT;
    endcase
    ready_nx = (state_nx == RF_READY);
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_WR write ports with highest-index priority,
// NUM_RD registered read ports, hardware clear sweep after reset or on request.
// Optional feature macro RF_BYPASS_EN: a read hitting an address written in
// the same cycle returns the new write data instead of the stored value.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int SIZE_REGFILE = 5,
  parameter int NUM_RD       = 2,
  parameter int NUM_WR       = 2,
  parameter int ZERO_REG     = 1
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_mp_if.slave  bus
);

  localparam int DEPTH = 2 ** SIZE_REGFILE;
`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                          ready;
  logic                          sweep_we;
  logic [SIZE_REGFILE-1:0]       sweep_addr;
  logic [DATA_WIDTH-1:0]         mem [DEPTH];
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_word_p0;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data_p1;
  logic [NUM_RD-1:0]             vld_p1;

  reg_file_clr_seq #(
    .SIZE_REGFILE (SIZE_REGFILE)
  ) u_clr_seq (
    .clk        (clk),
    .rst        (rst),
    .clr        (bus.rg_clr),
    .ready      (ready),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr)
  );

  // Storage update: sweep zeroes one entry per cycle, otherwise the enabled
  // write ports commit in index order so the highest index wins a collision
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_addr] <= '0;
    end else if (ready) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.rg_wrt_en[w] && !(ZERO_REG != 0 && bus.rg_wrt_dest[w] == '0))
          mem[bus.rg_wrt_dest[w]] <= bus.rg_wrt_data[w];
      end
    end
  end

  // Stage p0: array lookup, optional same-cycle write forwarding, zero entry
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_word_p0[i] = mem[bus.rg_rd_addr[i]];
      if (BYPASS) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (ready && bus.rg_wrt_en[w] && bus.rg_wrt_dest[w] == bus.rg_rd_addr[i])
            rd_word_p0[i] = bus.rg_wrt_data[w];
        end
      end
      if (ZERO_REG != 0 && bus.rg_rd_addr[i] == '0) rd_word_p0[i] = '0;
    end
  end

  // Stage p1: registered read data holds when not enabled; valid pulses per read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_p1 <= '0;
      vld_p1     <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        vld_p1[i] <= ready && bus.rg_rd_en[i];
        if (ready && bus.rg_rd_en[i]) rd_data_p1[i] <= rd_word_p0[i];
      end
    end
  end

  assign bus.rg_ready    = ready;
  assign bus.rg_rd_data  = rd_data_p1;
  assign bus.rg_rd_valid = vld_p1;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp with default parameters.
module tb_reg_file_mp;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cnt;

  reg_file_mp_if #(
    .DATA_WIDTH(32), .SIZE_REGFILE(5), .NUM_RD(2), .NUM_WR(2)
  ) bus ();

  reg_file_mp #(
    .DATA_WIDTH(32), .SIZE_REGFILE(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rg_clr      = 1'b0;
    bus.rg_wrt_en   = '0;
    bus.rg_wrt_dest = '0;
    bus.rg_wrt_data = '0;
    bus.rg_rd_en    = '0;
    bus.rg_rd_addr  = '0;
  endtask

  // counts edges from now until rg_ready rises, bounded
  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.rg_ready && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic wr(input int port, input logic [4:0] a, input logic [31:0] d);
    bus.rg_wrt_en[port]   = 1'b1;
    bus.rg_wrt_dest[port] = a;
    bus.rg_wrt_data[port] = d;
  endtask

  task automatic rd(input int port, input logic [4:0] a);
    bus.rg_rd_en[port]   = 1'b1;
    bus.rg_rd_addr[port] = a;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    idle();
    #22;
    // 1: reset state and INIT sweep length
    chk("rst_ready", {31'd0, bus.rg_ready}, 32'd0);
    chk("rst_valid", {30'd0, bus.rg_rd_valid}, 32'd0);
    chk("rst_data0", bus.rg_rd_data[0], 32'd0);
    chk("rst_data1", bus.rg_rd_data[1], 32'd0);
    rst = 1'b1;
    wait_ready(cnt);
    chk("init_cycles", cnt, 32'd32);
    for (int i = 0; i < 32; i++) begin
      idle();
      rd(0, 5'(i));
      rd(1, 5'(31 - i));
      step();
      chk("init_rd0", bus.rg_rd_data[0], 32'd0);
      chk("init_rd1", bus.rg_rd_data[1], 32'd0);
    end
    chk("init_vld", {30'd0, bus.rg_rd_valid}, 32'd3);

    // 2: write then read, one-cycle read latency, hold when not enabled
    idle(); wr(0, 5'd3, 32'hDEADBEEF); step();
    idle(); rd(1, 5'd3); step();
    chk("t2_vld1", {31'd0, bus.rg_rd_valid[1]}, 32'd1);
    chk("t2_vld0", {31'd0, bus.rg_rd_valid[0]}, 32'd0);
    chk("t2_data", bus.rg_rd_data[1], 32'hDEADBEEF);
    idle(); step();
    chk("t2_vld_off", {31'd0, bus.rg_rd_valid[1]}, 32'd0);
    chk("t2_hold", bus.rg_rd_data[1], 32'hDEADBEEF);

    // 3: same-address collision, port 1 wins
    idle(); wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22); step();
    idle(); rd(0, 5'd7); step();
    chk("t3_prio", bus.rg_rd_data[0], 32'h22);

    // 4: entry 0 is hardwired zero
    idle(); wr(1, 5'd0, 32'hFFFF); step();
    idle(); rd(0, 5'd0); step();
    chk("t4_zero", bus.rg_rd_data[0], 32'd0);
    chk("t4_vld", {31'd0, bus.rg_rd_valid[0]}, 32'd1);

    // 5: read and write of the same address in one cycle
    idle(); wr(0, 5'd5, 32'h5A); step();
    idle(); wr(1, 5'd5, 32'hA5); rd(0, 5'd5); step();
`ifdef RF_BYPASS_EN
    chk("t5_same", bus.rg_rd_data[0], 32'hA5);
`else
    chk("t5_same", bus.rg_rd_data[0], 32'h5A);
`endif
    idle(); rd(0, 5'd5); step();
    chk("t5_next", bus.rg_rd_data[0], 32'hA5);

    // 6: clear with concurrent write/read, then async reset mid-sweep
    idle(); bus.rg_clr = 1'b1; wr(0, 5'd9, 32'h9); rd(1, 5'd3); step();
    chk("t6_ready_drop", {31'd0, bus.rg_ready}, 32'd0);
    chk("t6_rd_done", bus.rg_rd_data[1], 32'hDEADBEEF);
    chk("t6_rd_vld", {31'd0, bus.rg_rd_valid[1]}, 32'd1);
    idle(); rd(1, 5'd3); wr(0, 5'd12, 32'h12); step();
    chk("t6_no_vld", {31'd0, bus.rg_rd_valid[1]}, 32'd0);
    chk("t6_hold", bus.rg_rd_data[1], 32'hDEADBEEF);
    idle();
    for (int i = 0; i < 8; i++) step();
    chk("t6_mid_sweep", {31'd0, bus.rg_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("t6_arst_data", bus.rg_rd_data[1], 32'd0);
    chk("t6_arst_ready", {31'd0, bus.rg_ready}, 32'd0);
    #2;
    rst = 1'b1;
    wait_ready(cnt);
    chk("t6_restart_cycles", cnt, 32'd32);
    idle(); rd(0, 5'd9); rd(1, 5'd3); step();
    chk("t6_addr9", bus.rg_rd_data[0], 32'd0);
    chk("t6_addr3", bus.rg_rd_data[1], 32'd0);
    idle(); rd(0, 5'd12); rd(1, 5'd7); step();
    chk("t6_addr12", bus.rg_rd_data[0], 32'd0);
    chk("t6_addr7", bus.rg_rd_data[1], 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
